// File: rtl/reset_sequencer_if.sv
// Interface for the reset sequencer: software restart request, per-channel ready
// handshake, per-channel reset outputs and status.
interface reset_sequencer_if #(
   parameter int NumOut = 3
);
   localparam int ChW = (NumOut > 1) ? $clog2(NumOut) : 1;

   logic              sw_reset_req;
   logic [NumOut-1:0] chan_ready;
   logic [NumOut-1:0] rst_out;
   logic              seq_done;
   logic              timeout_err;
   logic [ChW-1:0]    err_chan;

   modport master (
      input  sw_reset_req,
      input  chan_ready,
      output rst_out,
      output seq_done,
      output timeout_err,
      output err_chan
   );

   modport slave (
      output sw_reset_req,
      output chan_ready,
      input  rst_out,
      input  seq_done,
      input  timeout_err,
      input  err_chan
   );
endinterface

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises reset_in, holds all channels in reset, then releases
// them one at a time with a fixed gap and an optional per-channel ready handshake.
module reset_sequencer #(
   parameter int              SyncDepth    = 2,
   parameter int              NumOut       = 3,
   parameter int              HoldCycles   = 16,
   parameter int              GapCycles    = 4,
   parameter logic [NumOut-1:0] ReadyMask  = '0,
   parameter int              ReadyTimeout = 1024,
   parameter bit              OutActiveLow = 1'b0
) (
   input logic               clk,
   input logic               reset_in,
   reset_sequencer_if.master bus
);
   localparam int ChW     = (NumOut > 1) ? $clog2(NumOut) : 1;
   localparam int MaxHg   = (HoldCycles > GapCycles) ? HoldCycles : GapCycles;
   localparam int MaxCnt  = (MaxHg > ReadyTimeout) ? MaxHg : ReadyTimeout;
   localparam int CntW    = (MaxCnt > 1) ? $clog2(MaxCnt) : 1;
   localparam bit UseTimeout = (ReadyTimeout > 0);

   localparam logic [CntW-1:0] HoldLast    = CntW'(HoldCycles - 1);
   localparam logic [CntW-1:0] GapLast     = CntW'(GapCycles - 1);
   localparam logic [CntW-1:0] TimeoutLast = CntW'(UseTimeout ? ReadyTimeout - 1 : 0);
   localparam logic [ChW-1:0]  LastChan    = ChW'(NumOut - 1);

   typedef enum logic [1:0] {ST_HOLD, ST_GAP, ST_WAIT, ST_DONE} state_t;

   (* ASYNC_REG = "TRUE", IOB = "FALSE" *) logic [SyncDepth-1:0] sync_reg;
   logic sync_out;

   state_t            state_reg, state_next;
   logic [CntW-1:0]   cnt_reg, cnt_next;
   logic [ChW-1:0]    chan_reg, chan_next;
   logic [NumOut-1:0] rel_reg, rel_next;
   logic              done_reg, done_next;
   logic              terr_reg, terr_next;
   logic [ChW-1:0]    echan_reg, echan_next;

   logic [ChW-1:0]    chan_inc;
   logic              mask_inc;
   logic              ready_cur;

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         sync_reg <= '0;
      end else begin
         sync_reg <= {sync_reg[SyncDepth-2:0], 1'b1};
      end
   end

   assign sync_out = sync_reg[SyncDepth-1];

   always_ff @(posedge clk or negedge reset_in) begin
      if (!reset_in) begin
         state_reg <= ST_HOLD;
         cnt_reg   <= '0;
         chan_reg  <= '0;
         rel_reg   <= '0;
         done_reg  <= 1'b0;
         terr_reg  <= 1'b0;
         echan_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         chan_reg  <= chan_next;
         rel_reg   <= rel_next;
         done_reg  <= done_next;
         terr_reg  <= terr_next;
         echan_reg <= echan_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      chan_next  = chan_reg;
      rel_next   = rel_reg;
      done_next  = done_reg;
      terr_next  = terr_reg;
      echan_next = echan_reg;
      chan_inc   = chan_reg + 1'b1;
      mask_inc   = 1'b0;
      ready_cur  = 1'b0;
      // Ready is only looked at for the channel currently being waited on.
      for (int i = 0; i < NumOut; i++) begin
         if (chan_inc == ChW'(i)) mask_inc = ReadyMask[i];
         if (chan_reg == ChW'(i)) ready_cur = bus.chan_ready[i];
      end

      if (bus.sw_reset_req) begin
         state_next = ST_HOLD;
         cnt_next   = '0;
         chan_next  = '0;
         rel_next   = '0;
         done_next  = 1'b0;
      end else begin
         case (state_reg)
            ST_HOLD: begin
               if (sync_out) begin
                  if (cnt_reg == HoldLast) begin
                     cnt_next    = '0;
                     chan_next   = '0;
                     rel_next[0] = 1'b1;
                     if (ReadyMask[0]) begin
                        state_next = ST_WAIT;
                     end else if (NumOut == 1) begin
                        state_next = ST_DONE;
                        done_next  = 1'b1;
                     end else begin
                        state_next = ST_GAP;
                     end
                  end else begin
                     cnt_next = cnt_reg + 1'b1;
                  end
               end
            end
            ST_GAP: begin
               if (cnt_reg == GapLast) begin
                  cnt_next  = '0;
                  chan_next = chan_inc;
                  for (int i = 0; i < NumOut; i++) begin
                     if (chan_inc == ChW'(i)) rel_next[i] = 1'b1;
                  end
                  if (mask_inc) begin
                     state_next = ST_WAIT;
                  end else if (chan_inc == LastChan) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_GAP;
                  end
               end else begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            ST_WAIT: begin
               if (ready_cur || (UseTimeout && cnt_reg == TimeoutLast)) begin
                  // A timeout is flagged and then treated exactly like ready.
                  if (!ready_cur) begin
                     terr_next  = 1'b1;
                     echan_next = chan_reg;
                  end
                  cnt_next = '0;
                  if (chan_reg == LastChan) begin
                     state_next = ST_DONE;
                     done_next  = 1'b1;
                  end else begin
                     state_next = ST_GAP;
                  end
               end else if (UseTimeout) begin
                  cnt_next = cnt_reg + 1'b1;
               end
            end
            default: begin
               state_next = ST_DONE;
            end
         endcase
      end
   end

   for (genvar gi = 0; gi < NumOut; gi++) begin : g_out
      assign bus.rst_out[gi] = OutActiveLow ? rel_reg[gi] : ~rel_reg[gi];
   end

   assign bus.seq_done    = done_reg;
   assign bus.timeout_err = terr_reg;
   assign bus.err_chan    = echan_reg;
endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: main instance (3 channels, channel 1 handshaked,
// timeout 8) plus an active-low single-channel instance sharing clock and reset.
module tb_reset_sequencer;
   logic clk      = 1'b0;
   logic clk_en   = 1'b1;
   logic reset_in = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   int   edge_n   = 0;

   reset_sequencer_if #(.NumOut(3)) bus_a ();
   reset_sequencer_if #(.NumOut(1)) bus_b ();

   reset_sequencer #(
      .SyncDepth(2), .NumOut(3), .HoldCycles(16), .GapCycles(4),
      .ReadyMask(3'b010), .ReadyTimeout(8), .OutActiveLow(1'b0)
   ) dut_a (
      .clk(clk), .reset_in(reset_in), .bus(bus_a.master)
   );

   reset_sequencer #(
      .SyncDepth(4), .NumOut(1), .HoldCycles(16), .GapCycles(4),
      .ReadyMask(1'b0), .ReadyTimeout(8), .OutActiveLow(1'b1)
   ) dut_b (
      .clk(clk), .reset_in(reset_in), .bus(bus_b.master)
   );

   // Clock parks low when disabled so async behaviour can be tested with no edges.
   always #5 clk = clk_en ? ~clk : 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s @edge %0d: got %0h expected %0h", tag, edge_n, got, exp);
      end else begin
         $display("ok   %s @edge %0d: %0h", tag, edge_n, got);
      end
   endtask

   task automatic go_to_edge(input int k);
      while (edge_n < k) begin
         @(posedge clk);
         edge_n++;
      end
      #1;
   endtask

   task automatic pulse_reset();
      @(negedge clk);
      reset_in = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      reset_in = 1'b1;
      edge_n   = 0;
   endtask

   task automatic check_a(input string tag, input logic [2:0] rst, input logic done);
      check({tag, ".rst_out"}, 32'(bus_a.rst_out), 32'(rst));
      check({tag, ".seq_done"}, 32'(bus_a.seq_done), 32'(done));
   endtask

   // Stop the clock, drop reset_in, expect immediate assertion, then restart at edge 0.
   task automatic async_drop(input string tag);
      @(negedge clk);
      clk_en = 1'b0;
      #7;
      reset_in = 1'b0;
      #2;
      check_a({tag, ".async"}, 3'b111, 1'b0);
      check({tag, ".terr_clr"}, 32'(bus_a.timeout_err), 32'd0);
      check({tag, ".echan_clr"}, 32'(bus_a.err_chan), 32'd0);
      check({tag, ".b_async"}, 32'(bus_b.rst_out), 32'd0);
      #5;
      reset_in = 1'b1;
      edge_n   = 0;
      #2;
      clk_en = 1'b1;
   endtask

   task automatic scen1_timing(input string tag);
      go_to_edge(17); check_a({tag, ".e17"}, 3'b111, 1'b0);
      go_to_edge(18); check_a({tag, ".e18"}, 3'b110, 1'b0);
      go_to_edge(21); check_a({tag, ".e21"}, 3'b110, 1'b0);
      go_to_edge(22); check_a({tag, ".e22"}, 3'b100, 1'b0);
      go_to_edge(26); check_a({tag, ".e26"}, 3'b100, 1'b0);
      go_to_edge(27); check_a({tag, ".e27"}, 3'b000, 1'b1);
      check({tag, ".terr"}, 32'(bus_a.timeout_err), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bus_a.sw_reset_req = 1'b0;
      bus_a.chan_ready   = 3'b111;
      bus_b.sw_reset_req = 1'b0;
      bus_b.chan_ready   = 1'b0;

      // Reset state while reset_in is low with the clock running.
      repeat (4) @(posedge clk);
      #1;
      check_a("rst", 3'b111, 1'b0);
      check("rst.terr", 32'(bus_a.timeout_err), 32'd0);
      check("rst.echan", 32'(bus_a.err_chan), 32'd0);
      check("rst.b_rst_out", 32'(bus_b.rst_out), 32'd0);
      check("rst.b_done", 32'(bus_b.seq_done), 32'd0);

      // Run A: ready tied high; active-low instance checked alongside.
      pulse_reset();
      go_to_edge(17); check_a("a.e17", 3'b111, 1'b0);
      go_to_edge(18); check_a("a.e18", 3'b110, 1'b0);
      go_to_edge(19);
      check("b.e19.rst_out", 32'(bus_b.rst_out), 32'd0);
      check("b.e19.done", 32'(bus_b.seq_done), 32'd0);
      go_to_edge(20);
      check("b.e20.rst_out", 32'(bus_b.rst_out), 32'd1);
      check("b.e20.done", 32'(bus_b.seq_done), 32'd1);
      go_to_edge(21); check_a("a.e21", 3'b110, 1'b0);
      go_to_edge(22); check_a("a.e22", 3'b100, 1'b0);
      go_to_edge(26); check_a("a.e26", 3'b100, 1'b0);
      go_to_edge(27); check_a("a.e27", 3'b000, 1'b1);
      check("a.terr", 32'(bus_a.timeout_err), 32'd0);

      // Software reset held across edges 30..35 while in DONE.
      go_to_edge(29);
      bus_a.sw_reset_req = 1'b1;
      go_to_edge(30); check_a("sw6.e30", 3'b111, 1'b0);
      go_to_edge(35); check_a("sw6.e35", 3'b111, 1'b0);
      bus_a.sw_reset_req = 1'b0;
      go_to_edge(50); check_a("sw6.e50", 3'b111, 1'b0);
      go_to_edge(51); check_a("sw6.e51", 3'b110, 1'b0);
      check("b.sw_isolated", 32'(bus_b.rst_out), 32'd1);

      // Run B: channel 1 never ready; others high but outside their window.
      bus_a.chan_ready = 3'b101;
      pulse_reset();
      go_to_edge(22); check_a("b2.e22", 3'b100, 1'b0);
      go_to_edge(29);
      check("b2.e29.terr", 32'(bus_a.timeout_err), 32'd0);
      check_a("b2.e29", 3'b100, 1'b0);
      go_to_edge(30);
      check("b2.e30.terr", 32'(bus_a.timeout_err), 32'd1);
      check("b2.e30.echan", 32'(bus_a.err_chan), 32'd1);
      check_a("b2.e30", 3'b100, 1'b0);
      go_to_edge(33); check_a("b2.e33", 3'b100, 1'b0);
      go_to_edge(34); check_a("b2.e34", 3'b000, 1'b1);

      // One-cycle software reset sampled at edge 40.
      go_to_edge(39);
      bus_a.sw_reset_req = 1'b1;
      go_to_edge(40);
      check_a("sw3.e40", 3'b111, 1'b0);
      check("sw3.e40.terr", 32'(bus_a.timeout_err), 32'd1);
      check("sw3.e40.echan", 32'(bus_a.err_chan), 32'd1);
      bus_a.sw_reset_req = 1'b0;
      go_to_edge(55); check_a("sw3.e55", 3'b111, 1'b0);
      go_to_edge(56); check_a("sw3.e56", 3'b110, 1'b0);
      check("sw3.e56.terr", 32'(bus_a.timeout_err), 32'd1);

      // Async reset with the clock stopped clears the sticky error.
      go_to_edge(59);
      async_drop("c4a");
      bus_a.chan_ready = 3'b111;
      go_to_edge(19); check_a("c4.e19", 3'b110, 1'b0);
      async_drop("c4b");
      scen1_timing("c4r");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
